// File: rtl/lsu_mem_master_if.sv
// Bus bundle between the core-side LSU request/response channel and data memory.
// master: view of lsu_mem_master; slave: view of the core pipeline plus memory.
interface lsu_mem_master_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_wen;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_valid;
   logic [31:0] mem_raddr;
   logic        mem_wen;
   logic [31:0] mem_waddr;
   logic [31:0] mem_wdata;
   logic [7:0]  mem_wmask;
   logic [31:0] mem_rdata;

   modport master (
      input  req_valid, req_wen, req_size, req_signed,
      input  req_addr, req_wdata, resp_ready, mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_err,
      output mem_valid, mem_raddr, mem_wen, mem_waddr,
      output mem_wdata, mem_wmask
   );

   modport slave (
      output req_valid, req_wen, req_size, req_signed,
      output req_addr, req_wdata, resp_ready, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_err,
      input  mem_valid, mem_raddr, mem_wen, mem_waddr,
      input  mem_wdata, mem_wmask
   );
endinterface

// File: rtl/lsu_mem_master.sv
// Load/store unit memory master: one request -> one single-cycle memory access -> response.
// Ports: clk, reset (sync, active-high), bus (lsu_mem_master_if.master: req/resp/mem).
module lsu_mem_master #(
   parameter bit CHECK_ALIGN = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   lsu_mem_master_if.master    bus
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next;

   logic        r_wen;
   logic [1:0]  r_size;
   logic        r_signed;
   logic [1:0]  r_off;
   logic [3:0]  r_wmask;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_rdata;
   logic        r_err;

   logic        w_accept;
   logic        w_err;
   logic [1:0]  w_off;
   logic [3:0]  w_wmask;
   logic [31:0] w_wdata;
   logic [31:0] w_shifted;
   logic [31:0] w_ext;
   logic        w_active;

   assign w_accept = bus.req_valid & bus.req_ready;

   // Alignment check; with checking disabled the offending
   // low offset bits are dropped instead.
   always_comb begin
      w_err = 1'b0;
      w_off = bus.req_addr[1:0];
      unique case (bus.req_size)
         2'd1: begin
            if (w_off[0]) begin
               if (CHECK_ALIGN) w_err = 1'b1;
               else             w_off[0] = 1'b0;
            end
         end
         2'd2: begin
            if (w_off != 2'd0) begin
               if (CHECK_ALIGN) w_err = 1'b1;
               else             w_off = 2'd0;
            end
         end
         2'd3: w_err = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      w_wmask = 4'b0000;
      if (bus.req_wen) begin
         unique case (bus.req_size)
            2'd0:    w_wmask = 4'b0001 << w_off;
            2'd1:    w_wmask = 4'b0011 << w_off;
            2'd2:    w_wmask = 4'b1111;
            default: w_wmask = 4'b0000;
         endcase
      end
   end

   assign w_wdata   = bus.req_wdata << {w_off, 3'b000};
   assign w_shifted = bus.mem_rdata >> {r_off, 3'b000};

   always_comb begin
      w_ext = w_shifted;
      unique case (r_size)
         2'd0: w_ext = {{24{r_signed & w_shifted[7]}},
                        w_shifted[7:0]};
         2'd1: w_ext = {{16{r_signed & w_shifted[15]}},
                        w_shifted[15:0]};
         default: w_ext = w_shifted;
      endcase
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (w_accept) w_next = w_err ? S_RESP : S_ACCESS;
         end
         S_ACCESS: w_next = S_RESP;
         S_RESP: begin
            if (bus.resp_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wen    <= 1'b0;
         r_size   <= 2'd0;
         r_signed <= 1'b0;
         r_off    <= 2'd0;
         r_wmask  <= 4'd0;
         r_addr   <= 32'd0;
         r_wdata  <= 32'd0;
         r_rdata  <= 32'd0;
         r_err    <= 1'b0;
      end else begin
         if (w_accept) begin
            r_wen    <= bus.req_wen;
            r_size   <= bus.req_size;
            r_signed <= bus.req_signed;
            r_off    <= w_off;
            r_err    <= w_err;
            r_rdata  <= 32'd0;
            // A rejected request leaves the memory side untouched.
            if (!w_err) begin
               r_addr  <= {bus.req_addr[31:2], 2'b00};
               r_wdata <= w_wdata;
               r_wmask <= w_wmask;
            end
         end
         if (r_state == S_ACCESS && !r_wen) r_rdata <= w_ext;
      end
   end

   // Reset gates the strobe so a store caught mid-access is dropped.
   assign w_active       = (r_state == S_ACCESS) & ~reset;
   assign bus.req_ready  = (r_state == S_IDLE) & ~reset;
   assign bus.mem_valid  = w_active;
   assign bus.mem_wen    = w_active & r_wen;
   assign bus.mem_wmask  = w_active ? {4'b0000, r_wmask} : 8'h00;
   assign bus.mem_raddr  = r_addr;
   assign bus.mem_waddr  = r_addr;
   assign bus.mem_wdata  = r_wdata;
   assign bus.resp_valid = (r_state == S_RESP) & ~reset;
   assign bus.resp_rdata = r_rdata;
   assign bus.resp_err   = r_err;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master with a small word-addressed memory model.
// Ports: none (top-level bench).
module tb_lsu_mem_master;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   lsu_mem_master_if bus ();

   lsu_mem_master #(.CHECK_ALIGN(1'b1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   logic [31:0] mem [0:15];
   logic        init_we = 1'b0;
   logic [3:0]  init_idx = 4'd0;
   logic [31:0] init_data = 32'd0;

   always @(posedge clk) begin
      if (init_we) mem[init_idx] <= init_data;
      else if (bus.mem_valid && bus.mem_wen) begin
         for (int b = 0; b < 4; b++)
            if (bus.mem_wmask[b])
               mem[bus.mem_waddr[5:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end
   end

   assign bus.mem_rdata = mem[bus.mem_raddr[5:2]];

   logic [31:0] t_rd, t_ra, t_wa, t_wd;
   logic [7:0]  t_wm;
   logic        t_err;
   int          t_lat, t_nval, t_nwen;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic poke(input logic [3:0] idx, input logic [31:0] d);
      @(negedge clk);
      init_we = 1'b1; init_idx = idx; init_data = d;
      @(posedge clk);
      #1 init_we = 1'b0;
   endtask

   task automatic xact(input logic wen, input logic [1:0] size,
                       input logic sgn, input logic [31:0] addr,
                       input logic [31:0] wdata);
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_wen = wen; bus.req_size = size;
      bus.req_signed = sgn; bus.req_addr = addr; bus.req_wdata = wdata;
      t_rd = 32'hX; t_err = 1'bX; t_lat = 0; t_nval = 0; t_nwen = 0;
      t_ra = 32'd0; t_wa = 32'd0; t_wd = 32'd0; t_wm = 8'hFF;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (bus.mem_valid) begin
            t_nval++;
            t_ra = bus.mem_raddr; t_wa = bus.mem_waddr;
            t_wd = bus.mem_wdata; t_wm = bus.mem_wmask;
         end
         if (bus.mem_wen) t_nwen++;
         if (bus.resp_valid) begin
            t_lat = k; t_rd = bus.resp_rdata; t_err = bus.resp_err;
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   int acc, last, gap;

   initial begin
      bus.req_valid = 1'b0; bus.req_wen = 1'b0; bus.req_size = 2'd0;
      bus.req_signed = 1'b0; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
      bus.resp_ready = 1'b1;

      poke(4'd0, 32'h8012_3456);
      poke(4'd1, 32'hDEAD_BEEF);
      poke(4'd2, 32'h1122_3344);
      @(negedge clk);
      chk("rst_req_ready", bus.req_ready, 1'b0);
      chk("rst_resp_valid", bus.resp_valid, 1'b0);
      chk("rst_mem_valid", bus.mem_valid, 1'b0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("idle_req_ready", bus.req_ready, 1'b1);
      chk("idle_wmask", bus.mem_wmask, 8'h00);

      // 1: LW
      xact(1'b0, 2'd2, 1'b0, 32'h8000_0004, 32'd0);
      chk("lw_lat", t_lat, 2);
      chk("lw_nval", t_nval, 1);
      chk("lw_raddr", t_ra, 32'h8000_0004);
      chk("lw_wmask", t_wm, 8'h00);
      chk("lw_nwen", t_nwen, 0);
      chk("lw_rdata", t_rd, 32'hDEAD_BEEF);
      chk("lw_err", t_err, 1'b0);
      @(negedge clk);
      chk("lw_back_idle", bus.req_ready, 1'b1);

      // 2: LB / LBU at offset 3
      xact(1'b0, 2'd0, 1'b1, 32'h8000_0003, 32'd0);
      chk("lb_rdata", t_rd, 32'hFFFF_FF80);
      xact(1'b0, 2'd0, 1'b0, 32'h8000_0003, 32'd0);
      chk("lbu_rdata", t_rd, 32'h0000_0080);

      // 3: SH at offset 2
      xact(1'b1, 2'd1, 1'b0, 32'h8000_0002, 32'h0000_ABCD);
      chk("sh_waddr", t_wa, 32'h8000_0000);
      chk("sh_wdata", t_wd, 32'hABCD_0000);
      chk("sh_wmask", t_wm, 8'h0C);
      chk("sh_nwen", t_nwen, 1);
      chk("sh_rdata", t_rd, 32'd0);
      xact(1'b0, 2'd2, 1'b0, 32'h8000_0000, 32'd0);
      chk("sh_readback", t_rd, 32'hABCD_3456);
      xact(1'b0, 2'd1, 1'b1, 32'h8000_0002, 32'd0);
      chk("lh_rdata", t_rd, 32'hFFFF_ABCD);

      // 4: misaligned and illegal size
      xact(1'b0, 2'd2, 1'b0, 32'h8000_0001, 32'd0);
      chk("mis_nval", t_nval, 0);
      chk("mis_err", t_err, 1'b1);
      chk("mis_rdata", t_rd, 32'd0);
      chk("mis_lat", t_lat, 1);
      xact(1'b0, 2'd3, 1'b0, 32'h8000_0004, 32'd0);
      chk("sz3_err", t_err, 1'b1);
      chk("sz3_nval", t_nval, 0);

      // 5: response stall, then back-to-back
      bus.resp_ready = 1'b0;
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_wen = 1'b0; bus.req_size = 2'd2;
      bus.req_signed = 1'b0; bus.req_addr = 32'h8000_0004;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("stall_first", bus.resp_valid, 1'b1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_valid", bus.resp_valid, 1'b1);
         chk("stall_rdata", bus.resp_rdata, 32'hDEAD_BEEF);
         chk("stall_ready", bus.req_ready, 1'b0);
      end
      bus.resp_ready = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("stall_release", bus.req_ready, 1'b1);
      bus.req_valid = 1'b1;
      acc = 0; last = -1; gap = 0;
      for (int i = 0; i < 12; i++) begin
         if (bus.req_ready) begin
            if (last >= 0) gap = i - last;
            last = i;
            acc++;
         end
         @(negedge clk);
      end
      bus.req_valid = 1'b0;
      chk("b2b_count", acc, 4);
      chk("b2b_gap", gap, 3);
      chk("b2b_rdata", bus.resp_rdata, 32'hDEAD_BEEF);

      // 6: reset during SW access
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_wen = 1'b1; bus.req_size = 2'd2;
      bus.req_addr = 32'h8000_0008; bus.req_wdata = 32'hCAFE_F00D;
      @(posedge clk);
      #1 begin
         bus.req_valid = 1'b0;
         reset = 1'b1;
      end
      @(negedge clk);
      chk("rsta_mem_valid", bus.mem_valid, 1'b0);
      chk("rsta_mem_wen", bus.mem_wen, 1'b0);
      chk("rsta_wmask", bus.mem_wmask, 8'h00);
      chk("rsta_req_ready", bus.req_ready, 1'b0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rsta_mem_word", mem[2], 32'h1122_3344);
      chk("rsta_idle", bus.req_ready, 1'b1);
      chk("rsta_resp_valid", bus.resp_valid, 1'b0);
      chk("rsta_resp_err", bus.resp_err, 1'b0);
      chk("rsta_resp_rdata", bus.resp_rdata, 32'd0);
      chk("rsta_waddr", bus.mem_waddr, 32'd0);
      chk("rsta_wdata", bus.mem_wdata, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
